// File: rtl/multiword_add_seq.sv
// multiword_add_seq: wide unsigned add/subtract, one byte per clock through a
// shared 8-bit ripple-carry slice. LSB byte first, with a registered inter-byte
// carry. Operands enter on a valid/ready handshake and the result leaves on a
// second valid/ready handshake.
module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*WORDS-1:0] a,
  input  logic [8*WORDS-1:0] b,
  input  logic               cin,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*WORDS-1:0] sum,
  output logic               cout,
  output logic               busy
);

  localparam int W  = 8 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  logic [W-1:0]    a_lat_reg;
  logic [W-1:0]    b_lat_reg;
  logic            sub_lat_reg;
  logic            carry_reg;
  logic [IW-1:0]   idx_reg;
  logic [W-1:0]    sum_reg;
  logic            cout_reg;

  logic [W-1:0]    b_eff;
  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic [8:0]      slice_full;
  logic [7:0]      slice_sum;
  logic            slice_cout;
  logic [W-1:0]    sum_next;
  logic            last_byte;

  // Subtraction is A + ~B + 1; the +1 comes from the initial carry.
  assign b_eff = sub_lat_reg ? ~b_lat_reg : b_lat_reg;

  // Select the byte currently being processed.
  assign a_byte = a_lat_reg[8*idx_reg +: 8];
  assign b_byte = b_eff[8*idx_reg +: 8];

  // The shared 8-bit ripple-carry slice.
  assign slice_full = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_reg};
  assign slice_sum  = slice_full[7:0];
  assign slice_cout = slice_full[8];

  assign last_byte = (idx_reg == IW'(WORDS - 1));

  // Per-byte result update: only the byte addressed by idx changes in RUN;
  // unprocessed bytes keep their old value.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_sum_byte
    assign sum_next[8*gi +: 8] =
      (state_reg == RUN && idx_reg == IW'(gi)) ? slice_sum : sum_reg[8*gi +: 8];
  end

  // Sequencer FSM: accept operands, ripple through the bytes, hold the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      a_lat_reg   <= '0;
      b_lat_reg   <= '0;
      sub_lat_reg <= 1'b0;
      carry_reg   <= 1'b0;
      idx_reg     <= '0;
      sum_reg     <= '0;
      cout_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_lat_reg   <= a;
            b_lat_reg   <= b;
            sub_lat_reg <= sub;
            carry_reg   <= sub ? 1'b1 : cin;
            idx_reg     <= '0;
            state_reg   <= RUN;
          end
        end
        RUN: begin
          sum_reg   <= sum_next;
          carry_reg <= slice_cout;
          idx_reg   <= idx_reg + IW'(1);
          if (last_byte) begin
            cout_reg  <= slice_cout;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; in_ready additionally masks reset.
  assign in_ready  = (state_reg == IDLE) && rst_n;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq: directed vectors with hand-computed results for a
// 4-byte and a 1-byte instance of multiword_add_seq.
module tb_multiword_add_seq;

  logic        clk;
  logic        rst_n;

  // 4-byte instance
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        busy;

  // 1-byte instance
  logic        in_valid1;
  logic        in_ready1;
  logic [7:0]  a1;
  logic [7:0]  b1;
  logic        cin1;
  logic        sub1;
  logic        out_valid1;
  logic        out_ready1;
  logic [7:0]  sum1;
  logic        cout1;
  logic        busy1;

  int n_checks;
  int n_pass;

  multiword_add_seq #(.WORDS(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  multiword_add_seq #(.WORDS(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .sub       (sub1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation on the 4-byte instance, checking latency, result and
  // handshake. Operands and cin are scrambled right after accept.
  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic vcin, input logic vsub,
                        input logic [31:0] exp_sum, input logic exp_cout);
    int lat;
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    cin      = vcin;
    sub      = vsub;
    tick();
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    cin      = ~vcin;
    sub      = ~vsub;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
    check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
    check({tag, "_busy"}, 64'(busy), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ovalid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    $display("op %s: a=0x%08h b=0x%08h cin=%0b sub=%0b -> sum=0x%08h cout=%0b lat=%0d",
             tag, va, vb, vcin, vsub, sum, cout, lat);
  endtask

  initial begin
    int lat;
    int ov_seen;
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    cin        = 1'b0;
    sub        = 1'b0;
    out_ready  = 1'b0;
    in_valid1  = 1'b0;
    a1         = '0;
    b1         = '0;
    cin1       = 1'b0;
    sub1       = 1'b0;
    out_ready1 = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", 64'(in_ready), 64'd1);
    $display("reset: in_ready=%0b out_valid=%0b busy=%0b", in_ready, out_valid, busy);

    // Main function
    run_op("ripple",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    run_op("mixed",     32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0);
    run_op("mixed_c1",  32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0);
    run_op("sub_pos0",  32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
    run_op("sub_pos1",  32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1);
    run_op("sub_neg0",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    run_op("sub_neg1",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);

    // Backpressure in DONE with a competing request on the input
    in_valid = 1'b1;
    a        = 32'h1111_1111;
    b        = 32'h2222_2222;
    cin      = 1'b0;
    sub      = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_latency", 64'(lat), 64'd4);
    in_valid = 1'b1;
    a        = 32'hAAAA_AAAA;
    b        = 32'h5555_5555;
    cin      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_sum", 64'(sum), 64'h3333_3333);
      check("bp_cout", 64'(cout), 64'd0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      $display("backpressure cycle %0d: sum=0x%08h out_valid=%0b in_ready=%0b",
               i, sum, out_valid, in_ready);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    out_ready = 1'b0;
    check("bp_ovalid_drop", 64'(out_valid), 64'd0);
    check("bp_idle_in_ready", 64'(in_ready), 64'd1);
    check("bp_idle_busy", 64'(busy), 64'd0);
    check("bp_sum_kept", 64'(sum), 64'h3333_3333);
    $display("backpressure release: out_valid=%0b in_ready=%0b busy=%0b", out_valid, in_ready, busy);

    // Reset after two bytes processed
    in_valid = 1'b1;
    a        = 32'h1234_5678;
    b        = 32'h1111_1111;
    cin      = 1'b0;
    sub      = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) ov_seen++;
      tick();
    end
    check("midrst_no_ovalid", 64'(ov_seen), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_cout", 64'(cout), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    $display("mid-run reset: out_valid pulses=%0d sum=0x%08h cout=%0b", ov_seen, sum, cout);
    run_op("after_rst", 32'hDEAD_BEEF, 32'h0102_0304, 1'b0, 1'b0, 32'hDFAF_C1F3, 1'b0);

    // Single-byte instance
    in_valid1 = 1'b1;
    a1        = 8'hF0;
    b1        = 8'h20;
    cin1      = 1'b1;
    sub1      = 1'b0;
    tick();
    in_valid1 = 1'b0;
    a1        = 8'h00;
    b1        = 8'h00;
    cin1      = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      tick();
      lat++;
    end
    check("w1_latency", 64'(lat), 64'd1);
    check("w1_sum", 64'(sum1), 64'h11);
    check("w1_cout", 64'(cout1), 64'd1);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("w1_ovalid_drop", 64'(out_valid1), 64'd0);
    check("w1_in_ready", 64'(in_ready1), 64'd1);
    $display("op w1: a=0xf0 b=0x20 cin=1 -> sum=0x%02h cout=%0b lat=%0d", sum1, cout1, lat);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
